// File: rtl/eth_pkg.sv
// Shared types and constants for the RMII receive path.
package eth_pkg;
  typedef enum logic [2:0] {IDLE, RECV, WAIT_CK, REPORT, CLEAR} rx_state_t;

  localparam int ERR_CRC   = 0;
  localparam int ERR_LEN   = 1;
  localparam int ERR_ALIGN = 2;
  localparam int FCS_BYTES = 4;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame sequencer: forwards dibits to the CRC checker, collects its
// verdict, validates length/alignment and keeps per-frame statistics.
module rx_frame_ctrl
  import eth_pkg::*;
#(
  parameter int MIN_BYTES    = 64,
  parameter int MAX_BYTES    = 1518,
  parameter int DONE_TIMEOUT = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       axiid,
  input  logic             axiiv,
  output logic [1:0]       ck_axiid,
  output logic             ck_axiiv,
  output logic             ck_rst,
  input  logic             ck_done,
  input  logic             ck_kill,
  output logic             frame_valid,
  output logic             frame_good,
  output logic [2:0]       frame_err,
  output logic [11:0]      frame_len,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int DCNT_MAX = 4 * MAX_BYTES + 3;
  localparam int DCNT_W   = $clog2(DCNT_MAX + 1);
  localparam int BYTE_W   = DCNT_W - 2;
  localparam int TMR_W    = $clog2(DONE_TIMEOUT + 1);
  localparam int NCNT     = 3;

  rx_state_t                   r_state, w_next;
  logic                        r_axiiv_prev, r_armed;
  logic [DCNT_W-1:0]           r_dcnt;
  logic [TMR_W-1:0]            r_tmr;
  logic                        w_rise, w_start, w_fwd, w_tmo;
  logic [BYTE_W-1:0]           w_bytes;
  logic [2:0]                  w_err;
  logic [11:0]                 w_len;
  logic [NCNT-1:0]             w_inc;
  logic [NCNT-1:0][CNT_W-1:0]  w_cnt;

  // r_armed blocks a frame that was already running when reset released:
  // the reset value of r_axiiv_prev would otherwise fake a rising edge.
  assign w_rise  = axiiv & ~r_axiiv_prev;
  assign w_start = w_rise & r_armed & (r_state == IDLE);
  assign w_fwd   = w_start | ((r_state == RECV) & axiiv);
  assign w_tmo   = (r_tmr == TMR_W'(DONE_TIMEOUT - 1));
  assign w_bytes = r_dcnt[DCNT_W-1:2];
  assign w_len   = (w_bytes >= BYTE_W'(FCS_BYTES)) ? 12'(w_bytes - BYTE_W'(FCS_BYTES)) : '0;

  always_comb begin
    w_err            = '0;
    w_err[ERR_CRC]   = ck_done & ck_kill;
    w_err[ERR_LEN]   = (w_bytes < BYTE_W'(MIN_BYTES)) | (w_bytes > BYTE_W'(MAX_BYTES));
    w_err[ERR_ALIGN] = (|r_dcnt[1:0]) | ~ck_done;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    frame_valid = 1'b0;
    ck_rst      = 1'b0;
    case (r_state)
      IDLE:    if (w_start) w_next = RECV;
      RECV:    if (!axiiv) w_next = WAIT_CK;
      WAIT_CK: if (ck_done || w_tmo) w_next = REPORT;
      REPORT:  begin frame_valid = 1'b1; w_next = CLEAR; end
      CLEAR:   begin ck_rst = 1'b1; w_next = IDLE; end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_axiiv_prev <= 1'b0;
      r_armed      <= 1'b0;
      r_dcnt       <= '0;
      r_tmr        <= '0;
      ck_axiid     <= '0;
      ck_axiiv     <= 1'b0;
      frame_good   <= 1'b0;
      frame_err    <= '0;
      frame_len    <= '0;
    end else begin
      r_axiiv_prev <= axiiv;
      if (!axiiv) r_armed <= 1'b1;
      ck_axiiv <= w_fwd;
      ck_axiid <= w_fwd ? axiid : 2'b00;
      if (w_start)
        r_dcnt <= DCNT_W'(1);
      else if (r_state == RECV && axiiv && r_dcnt != DCNT_W'(DCNT_MAX))
        r_dcnt <= r_dcnt + DCNT_W'(1);
      r_tmr <= (r_state == WAIT_CK) ? r_tmr + TMR_W'(1) : '0;
      if (r_state == WAIT_CK && w_next == REPORT) begin
        frame_err  <= w_err;
        frame_good <= ~|w_err;
        frame_len  <= w_len;
      end
    end
  end

  assign w_inc[0] = frame_valid & frame_good;
  assign w_inc[1] = frame_valid & ~frame_good;
  assign w_inc[2] = w_rise & (r_state inside {WAIT_CK, REPORT, CLEAR});

  for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_inc[gi]),
      .cnt (w_cnt[gi])
    );
  end

  assign good_cnt = w_cnt[0];
  assign bad_cnt  = w_cnt[1];
  assign drop_cnt = w_cnt[2];
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Randomized bench for rx_frame_ctrl against a per-frame verdict model.
module tb_rx_frame_ctrl;
  localparam int MIN_B = 64;
  localparam int MAX_B = 1518;
  localparam int DT    = 16;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int DSAT  = 4 * MAX_B + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    axiid = '0;
  logic          axiiv = 1'b0;
  logic          ck_done = 1'b0;
  logic          ck_kill = 1'b0;
  logic [1:0]    ck_axiid;
  logic          ck_axiiv, ck_rst, frame_valid, frame_good;
  logic [2:0]    frame_err;
  logic [11:0]   frame_len;
  logic [CW-1:0] good_cnt, bad_cnt, drop_cnt;

  int n_chk = 0;
  int n_err = 0;
  int m_good = 0, m_bad = 0, m_drop = 0;

  rx_frame_ctrl #(
    .MIN_BYTES(MIN_B), .MAX_BYTES(MAX_B), .DONE_TIMEOUT(DT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv),
    .ck_axiid(ck_axiid), .ck_axiiv(ck_axiiv), .ck_rst(ck_rst),
    .ck_done(ck_done), .ck_kill(ck_kill),
    .frame_valid(frame_valid), .frame_good(frame_good), .frame_err(frame_err),
    .frame_len(frame_len), .good_cnt(good_cnt), .bad_cnt(bad_cnt), .drop_cnt(drop_cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic chk_cnts();
    chk("good_cnt", good_cnt, sat(m_good));
    chk("bad_cnt",  bad_cnt,  sat(m_bad));
    chk("drop_cnt", drop_cnt, sat(m_drop));
  endtask

  // nd dibits; verdict d cycles after axiiv falls (0 = never); ovl > 0 starts
  // an overrun frame of ovl dibits right after the fall; tight ends the task
  // in the cycle before IDLE so the next frame starts at the minimum gap.
  task automatic run_frame(input int nd, input int d, input bit kill,
                           input int ovl, input int gap, input bit tight);
    int fwd_bad, fv_n, fv_k, rc_n, rc_k, klen, dsat_n, bytes, e_len, e_lat;
    logic [1:0] v;
    logic [2:0] e_err;
    fwd_bad = 0; fv_n = 0; fv_k = -1; rc_n = 0; rc_k = -1;

    dsat_n = (nd < DSAT) ? nd : DSAT;
    bytes  = dsat_n / 4;
    e_err  = '0;
    e_err[0] = (d > 0) && kill;
    e_err[1] = (bytes < MIN_B) || (bytes > MAX_B);
    e_err[2] = (dsat_n % 4 != 0) || (d == 0);
    e_len  = (bytes >= 4) ? bytes - 4 : 0;
    e_lat  = (d > 0) ? d : DT;
    klen   = (DT + 3 > ovl + 2) ? DT + 3 : ovl + 2;

    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      axiiv = 1'b0; axiid = 2'($urandom);
      ck_done = ($urandom_range(0, 3) == 0); ck_kill = 1'($urandom);
      @(posedge clk); #1;
      if (ck_axiiv !== 1'b0 || frame_valid !== 1'b0) fwd_bad++;
    end
    for (int i = 0; i < nd; i++) begin
      @(negedge clk);
      v = 2'($urandom);
      axiid = v; axiiv = 1'b1;
      ck_done = ($urandom_range(0, 15) == 0); ck_kill = 1'($urandom);
      @(posedge clk); #1;
      if (ck_axiiv !== 1'b1 || ck_axiid !== v) fwd_bad++;
    end
    @(negedge clk);
    axiiv = 1'b0; axiid = 2'($urandom); ck_done = 1'b0; ck_kill = 1'($urandom);
    @(posedge clk); #1;
    if (ck_axiiv !== 1'b0) fwd_bad++;

    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      axiiv = (k <= ovl); axiid = 2'($urandom);
      ck_done = (d > 0) && ((k == d) ||
                ((k == d + 1 || k == d + 2) && $urandom_range(0, 1) == 1));
      ck_kill = (k == d) ? kill : 1'($urandom);
      @(posedge clk); #1;
      if (ck_axiiv !== 1'b0) fwd_bad++;
      if (frame_valid) begin
        fv_n++;
        if (fv_k < 0) begin
          fv_k = k;
          chk("err", frame_err, e_err);
          chk("good", frame_good, (e_err == 3'b000));
        end
      end
      if (ck_rst) begin
        rc_n++;
        if (rc_k < 0) rc_k = k;
      end
      if (k >= klen || (tight && fv_k >= 0 && k >= fv_k + 2)) break;
    end

    if (e_err == 3'b000) m_good++; else m_bad++;
    if (ovl > 0) m_drop++;
    chk("fwd", fwd_bad, 0);
    chk("fv_lat", fv_k, e_lat);
    chk("fv_cnt", fv_n, 1);
    chk("ckrst_lat", rc_k, e_lat + 1);
    chk("ckrst_cnt", rc_n, 1);
    chk("len", frame_len, e_len);
    chk("err_hold", frame_err, e_err);
    chk_cnts();
  endtask

  initial begin
    int bad;
    int nd, d, ovl, sel;
    bit tt, prev_tight;

    repeat (3) @(negedge clk);
    chk("rst_outs", {ck_axiid, ck_axiiv, ck_rst, frame_valid, frame_good,
                     frame_err, frame_len, good_cnt, bad_cnt, drop_cnt}, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    run_frame(256, 2, 1'b0, 0, 1, 1'b0);
    run_frame(256, 2, 1'b1, 0, 2, 1'b0);
    run_frame(84, 1, 1'b0, 0, 2, 1'b0);
    run_frame(258, 5, 1'b0, 0, 2, 1'b0);
    run_frame(256, 0, 1'b0, 0, 2, 1'b0);
    run_frame(256, 3, 1'b0, 10, 2, 1'b0);
    run_frame(252, DT, 1'b0, 0, 2, 1'b1);
    run_frame(256, 4, 1'b0, 0, 0, 1'b0);
    run_frame(16, 1, 1'b0, 0, 2, 1'b0);
    run_frame(12, 1, 1'b0, 0, 2, 1'b0);
    run_frame(6072, 2, 1'b0, 0, 2, 1'b0);
    run_frame(6076, 2, 1'b0, 0, 2, 1'b0);

    // Reset in the middle of a frame, with axiiv held high across release.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      axiiv = 1'b1; axiid = 2'($urandom); ck_done = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_outs", {ck_axiid, ck_axiiv, ck_rst, frame_valid, frame_good,
                         frame_err, frame_len, good_cnt, bad_cnt, drop_cnt}, 0);
    m_good = 0; m_bad = 0; m_drop = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      axiiv = (i < 30); axiid = 2'($urandom);
      ck_done = ($urandom_range(0, 3) == 0); ck_kill = 1'($urandom);
      @(posedge clk); #1;
      if (ck_axiiv !== 1'b0 || frame_valid !== 1'b0 || ck_rst !== 1'b0) bad++;
    end
    chk("rst_no_pickup", bad, 0);
    chk_cnts();
    run_frame(256, 2, 1'b0, 0, 2, 1'b0);

    prev_tight = 1'b0;
    for (int f = 0; f < 20; f++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       nd = 256 + $urandom_range(0, 8);
        1:       nd = $urandom_range(4, 300);
        2:       nd = 4 * $urandom_range(60, 70);
        default: nd = $urandom_range(1, 20);
      endcase
      d   = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, DT);
      ovl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 25) : 0;
      tt  = (ovl == 0) && ($urandom_range(0, 1) == 1);
      run_frame(nd, d, 1'($urandom), ovl, prev_tight ? 0 : $urandom_range(1, 4), tt);
      prev_tight = tt;
    end

    for (int f = 0; f < 18; f++) run_frame(4, 1, 1'($urandom), 1, 2, 1'b0);
    for (int f = 0; f < 18; f++) run_frame(256, 1, 1'b0, 0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
